// File: rtl/tsn_time_base.sv
// tsn_time_base: global time base for the TSN datapath.
// Free-running time counter with prescaler and step, absolute set with
// acknowledge, signed one-shot offset correction, and a periodic
// cycle-start generator. Per cycle the priority is set > adjust > tick.
module tsn_time_base #(
    parameter int TIME_W   = 32,
    parameter int STEP     = 1,
    parameter int PRESCALE = 1,
    parameter int ADJ_W    = 16,
    parameter int CYC_W    = 16
) (
    input  logic              sync_clk,
    input  logic              rst_n,
    input  logic              i_time_en,
    input  logic              i_set_valid,
    input  logic [TIME_W-1:0] i_set_time,
    output logic              o_set_ack,
    input  logic              i_adj_valid,
    input  logic [ADJ_W-1:0]  i_adj_offset,
    input  logic [CYC_W-1:0]  i_cycle_period,
    output logic [TIME_W-1:0] o_top_time,
    output logic [CYC_W-1:0]  o_cycle_pos,
    output logic              o_cycle_start,
    output logic              o_wrap
);

    // A one-bit prescaler is kept even for PRESCALE=1; it simply stays 0.
    localparam int                PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [TIME_W-1:0] STEP_V   = TIME_W'(STEP);

    logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic [CYC_W-1:0]  cycle_pos_q, cycle_pos_d;
    logic              set_ack_q, set_ack_d;
    logic              cycle_start_q, cycle_start_d;
    logic              wrap_q, wrap_d;

    logic              tick;
    logic [TIME_W:0]   tick_sum;
    logic [TIME_W-1:0] adj_ext;
    logic [TIME_W-1:0] adj_sum;
    logic [CYC_W-1:0]  cyc_last;
    logic signed [ADJ_W-1:0] adj_signed;

    // Tick strobe and the candidate time values for the tick and adjust paths.
    always_comb begin
        tick       = i_time_en && (pre_cnt_q == PRE_LAST);
        tick_sum   = {1'b0, time_q} + {1'b0, STEP_V};
        adj_signed = i_adj_offset;
        adj_ext    = TIME_W'(adj_signed);
        // An adjust folds in a concurrent tick so that tick is never lost.
        adj_sum    = time_q + adj_ext + (tick ? STEP_V : '0);
        cyc_last   = i_cycle_period - CYC_W'(1);
    end

    // Next-state selection: set overrides everything, adjust overrides the
    // plain tick update of time, the cycle generator follows the tick.
    always_comb begin
        pre_cnt_d     = pre_cnt_q;
        time_d        = time_q;
        cycle_pos_d   = cycle_pos_q;
        set_ack_d     = i_set_valid;
        cycle_start_d = 1'b0;
        wrap_d        = 1'b0;

        if (i_set_valid) begin
            time_d      = i_set_time;
            pre_cnt_d   = '0;
            cycle_pos_d = '0;
        end else begin
            if (i_time_en) begin
                pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
            end

            if (i_adj_valid) begin
                // Carry out of an adjusted sum is deliberately not reported.
                time_d = adj_sum;
            end else if (tick) begin
                time_d = tick_sum[TIME_W-1:0];
                wrap_d = tick_sum[TIME_W];
            end

            if (tick) begin
                if (i_cycle_period == '0) begin
                    cycle_pos_d = '0;
                end else if (cycle_pos_q >= cyc_last) begin
                    // ">=" also recovers when the period shrinks mid-cycle.
                    cycle_pos_d   = '0;
                    cycle_start_d = 1'b1;
                end else begin
                    cycle_pos_d = cycle_pos_q + CYC_W'(1);
                end
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge sync_clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q     <= '0;
            time_q        <= '0;
            cycle_pos_q   <= '0;
            set_ack_q     <= 1'b0;
            cycle_start_q <= 1'b0;
            wrap_q        <= 1'b0;
        end else begin
            pre_cnt_q     <= pre_cnt_d;
            time_q        <= time_d;
            cycle_pos_q   <= cycle_pos_d;
            set_ack_q     <= set_ack_d;
            cycle_start_q <= cycle_start_d;
            wrap_q        <= wrap_d;
        end
    end

    assign o_top_time    = time_q;
    assign o_cycle_pos   = cycle_pos_q;
    assign o_set_ack     = set_ack_q;
    assign o_cycle_start = cycle_start_q;
    assign o_wrap        = wrap_q;

endmodule

// File: tb/tb_tsn_time_base.sv
// tb_tsn_time_base: two instances of the time base.
//   A: TIME_W=32 STEP=1 PRESCALE=1 ADJ_W=16 CYC_W=16 (table vectors)
//   B: TIME_W=8  STEP=3 PRESCALE=4 ADJ_W=8  CYC_W=8  (wrap/prescale corners)
// Both run against a behavioural model during a randomized phase.
module tb_tsn_time_base;

    logic sync_clk = 1'b0;
    logic rst_n    = 1'b0;

    // Instance A signals
    logic        a_en, a_set, a_adj, a_ack, a_start, a_wrap;
    logic [31:0] a_stime, a_time;
    logic [15:0] a_off, a_per, a_pos;
    // Instance B signals
    logic        b_en, b_set, b_adj, b_ack, b_start, b_wrap;
    logic [7:0]  b_stime, b_time, b_off, b_per, b_pos;

    int checks = 0;
    int errors = 0;

    always #5 sync_clk = ~sync_clk;

    tsn_time_base #(.TIME_W(32), .STEP(1), .PRESCALE(1), .ADJ_W(16), .CYC_W(16)) dut_a (
        .sync_clk(sync_clk), .rst_n(rst_n), .i_time_en(a_en),
        .i_set_valid(a_set), .i_set_time(a_stime), .o_set_ack(a_ack),
        .i_adj_valid(a_adj), .i_adj_offset(a_off), .i_cycle_period(a_per),
        .o_top_time(a_time), .o_cycle_pos(a_pos), .o_cycle_start(a_start),
        .o_wrap(a_wrap)
    );

    tsn_time_base #(.TIME_W(8), .STEP(3), .PRESCALE(4), .ADJ_W(8), .CYC_W(8)) dut_b (
        .sync_clk(sync_clk), .rst_n(rst_n), .i_time_en(b_en),
        .i_set_valid(b_set), .i_set_time(b_stime), .o_set_ack(b_ack),
        .i_adj_valid(b_adj), .i_adj_offset(b_off), .i_cycle_period(b_per),
        .o_top_time(b_time), .o_cycle_pos(b_pos), .o_cycle_start(b_start),
        .o_wrap(b_wrap)
    );

    // ---------------- behavioural reference model ----------------
    typedef struct {
        longint t;      // time value, 0 .. 2^W-1
        int     phase;  // enabled clocks seen since last tick/set
        int     pos;
        bit     ack, st, wr;
    } mstate_t;

    mstate_t ma, mb;

    function automatic mstate_t mreset();
        mstate_t z;
        z.t = 0; z.phase = 0; z.pos = 0; z.ack = 0; z.st = 0; z.wr = 0;
        return z;
    endfunction

    // Time is an integer modulo 2^W; a tick happens on every PRESCALE-th
    // enabled clock; set restarts the phase and the cycle position.
    function automatic mstate_t mstep(mstate_t s, bit en, bit set, longint stv,
                                      bit adj, longint off, int period,
                                      int w, longint step, int presc);
        mstate_t n;
        longint  m;
        longint  sum;
        bit      tick;
        m    = longint'(1) << w;
        tick = en && ((s.phase + 1) == presc);
        n    = s;
        n.ack = set; n.st = 0; n.wr = 0;
        if (set) begin
            n.t = stv; n.phase = 0; n.pos = 0;
        end else begin
            if (en) n.phase = tick ? 0 : s.phase + 1;
            if (adj) begin
                sum = s.t + off + (tick ? step : 0);
                sum = sum % m;
                if (sum < 0) sum = sum + m;
                n.t = sum;
            end else if (tick) begin
                n.t  = (s.t + step) % m;
                n.wr = (s.t + step) >= m;
            end
            if (tick) begin
                if (period == 0) n.pos = 0;
                else if (s.pos + 1 >= period) begin n.pos = 0; n.st = 1; end
                else n.pos = s.pos + 1;
            end
        end
        return n;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: models follow the DUTs, outputs are sampled 1 time unit later.
    task automatic step_cycle();
        @(posedge sync_clk);
        if (!rst_n) begin
            ma = mreset(); mb = mreset();
        end else begin
            ma = mstep(ma, a_en, a_set, longint'(a_stime), a_adj,
                       longint'($signed(a_off)), int'(a_per), 32, 1, 1);
            mb = mstep(mb, b_en, b_set, longint'(b_stime), b_adj,
                       longint'($signed(b_off)), int'(b_per), 8, 3, 4);
        end
        #1;
    endtask

    task automatic cmp_a(input string tag, input longint t, input int pos,
                         input bit ack, input bit st, input bit wr);
        $display("%s A: time=%h pos=%0d ack=%0b start=%0b wrap=%0b", tag,
                 a_time, a_pos, a_ack, a_start, a_wrap);
        chk({tag, " A.time"},  longint'(a_time), t);
        chk({tag, " A.pos"},   longint'(a_pos), longint'(pos));
        chk({tag, " A.ack"},   longint'(a_ack), longint'(ack));
        chk({tag, " A.start"}, longint'(a_start), longint'(st));
        chk({tag, " A.wrap"},  longint'(a_wrap), longint'(wr));
    endtask

    task automatic cmp_b(input string tag, input longint t, input int pos,
                         input bit ack, input bit st, input bit wr);
        $display("%s B: time=%h pos=%0d ack=%0b start=%0b wrap=%0b", tag,
                 b_time, b_pos, b_ack, b_start, b_wrap);
        chk({tag, " B.time"},  longint'(b_time), t);
        chk({tag, " B.pos"},   longint'(b_pos), longint'(pos));
        chk({tag, " B.ack"},   longint'(b_ack), longint'(ack));
        chk({tag, " B.start"}, longint'(b_start), longint'(st));
        chk({tag, " B.wrap"},  longint'(b_wrap), longint'(wr));
    endtask

    task automatic b_drive(input bit en, input bit set, input logic [7:0] stv,
                           input bit adj, input logic [7:0] off);
        b_en = en; b_set = set; b_stime = stv; b_adj = adj; b_off = off;
    endtask

    // ---------------- vector table for instance A ----------------
    typedef struct {
        bit          en, set, adj;
        logic [31:0] stime;
        logic [15:0] off, per;
        logic [31:0] etime;
        int          epos;
        bit          eack, est, ewr;
    } vec_t;

    vec_t tbl[27];

    initial begin
        // en set adj stime off per | time pos ack start wrap
        tbl[0]  = '{1,0,0,32'h0,16'h0,16'd5, 32'd1,1,0,0,0};
        tbl[1]  = '{1,0,0,32'h0,16'h0,16'd5, 32'd2,2,0,0,0};
        tbl[2]  = '{1,0,0,32'h0,16'h0,16'd5, 32'd3,3,0,0,0};
        tbl[3]  = '{1,0,0,32'h0,16'h0,16'd5, 32'd4,4,0,0,0};
        tbl[4]  = '{1,0,0,32'h0,16'h0,16'd5, 32'd5,0,0,1,0};
        tbl[5]  = '{0,0,0,32'h0,16'h0,16'd5, 32'd5,0,0,0,0};
        tbl[6]  = '{1,1,1,32'h1000,16'd5,16'd5, 32'h1000,0,1,0,0};
        tbl[7]  = '{1,0,0,32'h0,16'h0,16'd5, 32'h1001,1,0,0,0};
        tbl[8]  = '{0,1,0,32'd100,16'h0,16'd5, 32'd100,0,1,0,0};
        tbl[9]  = '{1,0,1,32'h0,16'd5,16'd5, 32'd106,1,0,0,0};
        tbl[10] = '{0,0,1,32'h0,16'hFFF9,16'd5, 32'd99,1,0,0,0};
        tbl[11] = '{1,0,0,32'h0,16'h0,16'd0, 32'd100,0,0,0,0};
        tbl[12] = '{1,0,0,32'h0,16'h0,16'd0, 32'd101,0,0,0,0};
        tbl[13] = '{1,0,0,32'h0,16'h0,16'd1, 32'd102,0,0,1,0};
        tbl[14] = '{1,0,0,32'h0,16'h0,16'd1, 32'd103,0,0,1,0};
        tbl[15] = '{1,0,0,32'h0,16'h0,16'd3, 32'd104,1,0,0,0};
        tbl[16] = '{1,1,0,32'hFFFF_FFFF,16'h0,16'd3, 32'hFFFF_FFFF,0,1,0,0};
        tbl[17] = '{1,0,0,32'h0,16'h0,16'd3, 32'd0,1,0,0,1};
        tbl[18] = '{1,0,0,32'h0,16'h0,16'd3, 32'd1,2,0,0,0};
        tbl[19] = '{1,0,0,32'h0,16'h0,16'd3, 32'd2,0,0,1,0};
        tbl[20] = '{1,0,0,32'h0,16'h0,16'd5, 32'd3,1,0,0,0};
        tbl[21] = '{1,0,0,32'h0,16'h0,16'd5, 32'd4,2,0,0,0};
        tbl[22] = '{1,0,0,32'h0,16'h0,16'd5, 32'd5,3,0,0,0};
        tbl[23] = '{1,0,0,32'h0,16'h0,16'd5, 32'd6,4,0,0,0};
        tbl[24] = '{1,0,0,32'h0,16'h0,16'd3, 32'd7,0,0,1,0};
        tbl[25] = '{1,1,0,32'hFFFF_FFFE,16'h0,16'd3, 32'hFFFF_FFFE,0,1,0,0};
        tbl[26] = '{1,0,1,32'h0,16'd5,16'd3, 32'd4,1,0,0,0};
    end

    // ---------------- main sequence ----------------
    initial begin
        ma = mreset(); mb = mreset();
        a_en = 0; a_set = 0; a_adj = 0; a_stime = '0; a_off = '0; a_per = '0;
        b_en = 0; b_set = 0; b_adj = 0; b_stime = '0; b_off = '0; b_per = '0;

        // Reset state
        repeat (3) step_cycle();
        cmp_a("reset", 0, 0, 0, 0, 0);
        cmp_b("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Table-driven vectors on A
        for (int i = 0; i < 27; i++) begin
            a_en = tbl[i].en; a_set = tbl[i].set; a_adj = tbl[i].adj;
            a_stime = tbl[i].stime; a_off = tbl[i].off; a_per = tbl[i].per;
            step_cycle();
            cmp_a($sformatf("vec%0d", i), longint'(tbl[i].etime), tbl[i].epos,
                  tbl[i].eack, tbl[i].est, tbl[i].ewr);
        end
        a_en = 0; a_set = 0; a_adj = 0; a_per = '0;

        // B: set 0xFE, tick every 4th clock, wrap to 0x01 for exactly one cycle
        b_drive(1, 1, 8'hFE, 0, 8'h0);
        step_cycle(); cmp_b("wrap.set", 8'hFE, 0, 1, 0, 0);
        b_drive(1, 0, 8'h0, 0, 8'h0);
        for (int i = 0; i < 3; i++) begin
            step_cycle(); cmp_b($sformatf("wrap.wait%0d", i), 8'hFE, 0, 0, 0, 0);
        end
        step_cycle(); cmp_b("wrap.tick", 8'h01, 0, 0, 0, 1);
        step_cycle(); cmp_b("wrap.after", 8'h01, 0, 0, 0, 0);

        // B: adjust -4 from 0x02 without a tick
        b_drive(0, 1, 8'h02, 0, 8'h0);
        step_cycle(); cmp_b("adj.set", 8'h02, 0, 1, 0, 0);
        b_drive(0, 0, 8'h0, 1, 8'hFC);
        step_cycle(); cmp_b("adj.notick", 8'hFE, 0, 0, 0, 0);

        // B: adjust -4 from 0x02 coinciding with a tick (carry not reported)
        b_drive(1, 1, 8'h02, 0, 8'h0);
        step_cycle(); cmp_b("adjt.set", 8'h02, 0, 1, 0, 0);
        b_drive(1, 0, 8'h0, 0, 8'h0);
        repeat (3) step_cycle();
        cmp_b("adjt.wait", 8'h02, 0, 0, 0, 0);
        b_drive(1, 0, 8'h0, 1, 8'hFC);
        step_cycle(); cmp_b("adjt.tick", 8'h01, 0, 0, 0, 0);

        // B: enable low for 10 clocks freezes value and prescaler phase
        b_drive(0, 1, 8'h10, 0, 8'h0);
        step_cycle(); cmp_b("frz.set", 8'h10, 0, 1, 0, 0);
        b_drive(1, 0, 8'h0, 0, 8'h0);
        repeat (2) step_cycle();
        b_en = 0;
        repeat (10) step_cycle();
        cmp_b("frz.hold", 8'h10, 0, 0, 0, 0);
        b_en = 1;
        step_cycle(); cmp_b("frz.phase3", 8'h10, 0, 0, 0, 0);
        step_cycle(); cmp_b("frz.tick", 8'h13, 0, 0, 0, 0);
        b_en = 0;

        // A: async reset between clock edges at time 0x55
        a_set = 1; a_stime = 32'h50; a_en = 1;
        step_cycle();
        a_set = 0;
        repeat (5) step_cycle();
        cmp_a("arst.pre", 32'h55, 0, 0, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        cmp_a("arst.now", 0, 0, 0, 0, 0);
        cmp_b("arst.now", 0, 0, 0, 0, 0);
        step_cycle();
        rst_n = 1'b1;
        step_cycle(); cmp_a("arst.run1", 1, 0, 0, 0, 0);
        step_cycle(); cmp_a("arst.run2", 2, 0, 0, 0, 0);

        // Randomized phase on both instances against the model
        a_per = 16'd4; b_per = 8'd3;
        for (int i = 0; i < 400; i++) begin
            a_en  = ($urandom_range(0, 3) != 0);
            a_set = ($urandom_range(0, 15) == 0);
            a_stime = ($urandom_range(0, 1) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : 32'($urandom);
            a_adj = ($urandom_range(0, 7) == 0);
            a_off = 16'($urandom);
            if ($urandom_range(0, 19) == 0) a_per = 16'($urandom_range(0, 6));
            b_en  = ($urandom_range(0, 3) != 0);
            b_set = ($urandom_range(0, 15) == 0);
            b_stime = 8'($urandom);
            b_adj = ($urandom_range(0, 7) == 0);
            b_off = 8'($urandom);
            if ($urandom_range(0, 19) == 0) b_per = 8'($urandom_range(0, 6));
            step_cycle();
            cmp_a($sformatf("rnd%0d", i), ma.t, ma.pos, ma.ack, ma.st, ma.wr);
            cmp_b($sformatf("rnd%0d", i), mb.t, mb.pos, mb.ack, mb.st, mb.wr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
